pspin_alloc_arb: RTL and testbench
==================================

PSPIN_ALLOC_ARB -- requirements
Module: pspin_alloc_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of ingress requesters (2..16).
REQ-002 SHALL have parameter LEN_WIDTH, default 20: packet length width.
REQ-003 SHALL have parameter TAG_WIDTH, default 32: packet tag width.
REQ-004 SHALL have parameter CREDIT_WIDTH, default 8: in-flight counter width.
REQ-005 SHALL have parameter MAX_INFLIGHT, default 64: per-requester in-flight limit, at most 2^CREDIT_WIDTH-1.
REQ-006 SHALL have localparam SRC_WIDTH = max(1, clog2(NUM_REQ)).
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rstn  in  1  reset, asynchronous assert, active-low.
REQ-009 req_tag_i  in  NUM_REQ*TAG_WIDTH  per-requester tag; requester i occupies slice i.
REQ-010 req_len_i  in  NUM_REQ*LEN_WIDTH  per-requester packet length.
REQ-011 req_valid_i  in  NUM_REQ  per-requester valid.
REQ-012 req_ready_o  out  NUM_REQ  per-requester ready, combinational.
REQ-013 alloc_tag_o / alloc_len_o  out  TAG_WIDTH / LEN_WIDTH  registered request to the packet allocator.
REQ-014 alloc_src_o  out  SRC_WIDTH  index of the requester that owns the current output.
REQ-015 alloc_valid_o  out  1  output valid, registered.
REQ-016 alloc_ready_i  in  1  allocator ready.
REQ-017 release_valid_i  in  1  one packet of requester release_src_i has been freed.
REQ-018 release_src_i  in  SRC_WIDTH  requester index being released.
REQ-019 inflight_o  out  NUM_REQ*CREDIT_WIDTH  per-requester in-flight count.
REQ-020 release_err_o  out  32  count of invalid releases.

Function
REQ-021 SHALL hold a one-entry output register, EMPTY or FULL; alloc_valid_o = FULL.
REQ-022 A requester SHALL be eligible when req_valid_i[i]=1 and inflight[i] < MAX_INFLIGHT.
REQ-023 Output register SHALL be able to load when EMPTY, or when FULL and alloc_ready_i=1 in that cycle.
REQ-024 When able to load, SHALL pick the winner round-robin among eligible requesters: search from (last_grant+1) mod NUM_REQ upward with wrap; at most one winner per cycle.
REQ-025 Winner SHALL see req_ready_o=1 in the same cycle; all other req_ready_o bits SHALL be 0.
REQ-026 On winner handshake SHALL latch tag, len and index into the output; alloc_valid_o SHALL be 1 on the next cycle (1-cycle latency); last_grant SHALL become the winner.
REQ-027 FULL with alloc_ready_i=1 and no eligible requester SHALL go EMPTY; FULL with alloc_ready_i=0 SHALL hold all outputs stable.
REQ-028 Back-to-back handshakes SHALL sustain one transfer per cycle.
REQ-029 inflight[i] SHALL increment on acceptance from requester i.
REQ-030 inflight[i] SHALL decrement on release_valid_i with release_src_i=i.
REQ-031 Acceptance and release on the same index in the same cycle SHALL leave inflight unchanged.
REQ-032 A release with inflight=0 (not coincident with acceptance) or release_src_i >= NUM_REQ SHALL be ignored and SHALL increment release_err_o, which saturates at 2^32-1.
REQ-033 A requester at MAX_INFLIGHT SHALL become eligible in the cycle its release arrives; eligibility SHALL use the pre-update inflight value plus that cycle's release.
REQ-034 Requester lengths and tags SHALL pass through unmodified; drop and size decisions belong to the downstream allocator.

Reset
REQ-035 Asserting rstn low SHALL asynchronously clear state to EMPTY, alloc_valid_o=0, alloc_tag_o=0, alloc_len_o=0, alloc_src_o=0, all inflight=0, release_err_o=0 and last_grant=NUM_REQ-1, so requester 0 wins first.
REQ-036 req_ready_o SHALL be 0 while rstn is low.
REQ-037 Reset mid-transfer SHALL discard the held entry without a handshake.

Verification
REQ-038 All 4 requesters valid continuously, alloc_ready_i=1 -> grants 0,1,2,3,0 on consecutive cycles; alloc_valid_o stays high.
REQ-039 Requester 2 only, alloc_ready_i=0 for 5 cycles -> one acceptance; output held stable; req_ready_o[2]=0 until alloc_ready_i rises.
REQ-040 MAX_INFLIGHT=2, requester 1 sends 3 packets, no releases -> 2 accepted, third stalls; release_src_i=1 -> third accepted the same cycle, inflight[1]=2.
REQ-041 Acceptance and release on requester 0 in the same cycle with inflight[0]=3 -> inflight[0] stays 3.
REQ-042 Release on idle requester 3 -> inflight[3] stays 0, release_err_o=1.
REQ-043 rstn low while FULL -> alloc_valid_o=0 immediately; after release, requester 0 wins first.

Source files
------------

// File: rtl/pspin_alloc_arb_if.sv
// ============================================================================
//  Module   : pspin_alloc_arb_if
//  Brief    : Requester / allocator / release bundle for pspin_alloc_arb.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pspin_alloc_arb_if #(
    parameter int NUM_REQ      = 4,
    parameter int LEN_WIDTH    = 20,
    parameter int TAG_WIDTH    = 32,
    parameter int CREDIT_WIDTH = 8
);
    localparam int SRC_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ*TAG_WIDTH-1:0]    req_tag_i;
    logic [NUM_REQ*LEN_WIDTH-1:0]    req_len_i;
    logic [NUM_REQ-1:0]              req_valid_i;
    logic [NUM_REQ-1:0]              req_ready_o;
    logic [TAG_WIDTH-1:0]            alloc_tag_o;
    logic [LEN_WIDTH-1:0]            alloc_len_o;
    logic [SRC_WIDTH-1:0]            alloc_src_o;
    logic                            alloc_valid_o;
    logic                            alloc_ready_i;
    logic                            release_valid_i;
    logic [SRC_WIDTH-1:0]            release_src_i;
    logic [NUM_REQ*CREDIT_WIDTH-1:0] inflight_o;
    logic [31:0]                     release_err_o;

    modport slave (
        input  req_tag_i, req_len_i, req_valid_i, alloc_ready_i,
               release_valid_i, release_src_i,
        output req_ready_o, alloc_tag_o, alloc_len_o, alloc_src_o,
               alloc_valid_o, inflight_o, release_err_o
    );

    modport master (
        output req_tag_i, req_len_i, req_valid_i, alloc_ready_i,
               release_valid_i, release_src_i,
        input  req_ready_o, alloc_tag_o, alloc_len_o, alloc_src_o,
               alloc_valid_o, inflight_o, release_err_o
    );
endinterface

`default_nettype wire

// File: rtl/pspin_alloc_arb.sv
// ============================================================================
//  Module   : pspin_alloc_arb
//  Brief    : Round-robin ingress arbiter with per-requester in-flight limits
//             feeding a one-entry registered packet-allocator request.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pspin_alloc_arb #(
    parameter int NUM_REQ      = 4,
    parameter int LEN_WIDTH    = 20,
    parameter int TAG_WIDTH    = 32,
    parameter int CREDIT_WIDTH = 8,
    parameter int MAX_INFLIGHT = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    pspin_alloc_arb_if.slave     bus
);
    localparam int SRC_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CREDIT_WIDTH-1:0] c_max_inflight = CREDIT_WIDTH'(MAX_INFLIGHT);
    localparam logic [SRC_WIDTH-1:0]    c_last_rst     = SRC_WIDTH'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                             r_state;
    state_t                             w_state_nxt;
    logic [NUM_REQ-1:0][CREDIT_WIDTH-1:0] r_inflight;
    logic [SRC_WIDTH-1:0]               r_last_grant;
    logic [SRC_WIDTH-1:0]               r_src;
    logic [TAG_WIDTH-1:0]               r_tag;
    logic [LEN_WIDTH-1:0]               r_len;
    logic [31:0]                        r_rel_err;

    logic [NUM_REQ-1:0]                 w_rel_hit;
    logic [NUM_REQ-1:0]                 w_rel_credit;
    logic [NUM_REQ-1:0]                 w_eligible;
    logic [NUM_REQ-1:0]                 w_grant;
    logic [NUM_REQ-1:0]                 w_ready;
    logic [NUM_REQ-1:0]                 w_accept;
    logic [NUM_REQ-1:0]                 w_dec;
    logic                               w_can_load;
    logic                               w_found;
    logic [SRC_WIDTH-1:0]               w_winner;
    logic                               w_load;
    logic                               w_rel_err;
    logic [TAG_WIDTH-1:0]               w_sel_tag;
    logic [LEN_WIDTH-1:0]               w_sel_len;
    int                                 w_dist;
    int                                 w_best;

    // A release arriving this cycle frees a slot for eligibility before the counter updates.
    always_comb begin
        w_rel_hit    = '0;
        w_rel_credit = '0;
        w_eligible   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_rel_hit[i]    = bus.release_valid_i && (bus.release_src_i == SRC_WIDTH'(i));
            w_rel_credit[i] = w_rel_hit[i] && (r_inflight[i] != '0);
            w_eligible[i]   = bus.req_valid_i[i] &&
                ((r_inflight[i] - CREDIT_WIDTH'(w_rel_credit[i])) < c_max_inflight);
        end
    end

    assign w_can_load = (r_state == ST_EMPTY) || bus.alloc_ready_i;

    // Round-robin: smallest distance past last_grant wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_best   = NUM_REQ;
        w_dist   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = i - int'(r_last_grant) - 1;
            if (w_dist < 0) begin
                w_dist = w_dist + NUM_REQ;
            end
            if (w_eligible[i] && (w_dist < w_best)) begin
                w_best   = w_dist;
                w_winner = SRC_WIDTH'(i);
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        w_grant   = '0;
        w_sel_tag = '0;
        w_sel_len = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_grant[i] = w_can_load && w_found && (w_winner == SRC_WIDTH'(i));
            if (w_winner == SRC_WIDTH'(i)) begin
                w_sel_tag = bus.req_tag_i[i*TAG_WIDTH +: TAG_WIDTH];
                w_sel_len = bus.req_len_i[i*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    assign w_ready         = rstn ? w_grant : '0;
    assign w_accept        = w_ready & bus.req_valid_i;
    assign w_load          = |w_accept;
    assign bus.req_ready_o = w_ready;

    // A release on an empty counter is only legal when an acceptance lands on it the same cycle.
    always_comb begin
        w_dec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dec[i] = w_rel_hit[i] && ((r_inflight[i] != '0) || w_accept[i]);
        end
    end

    assign w_rel_err = bus.release_valid_i && !(|w_dec);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_load) w_state_nxt = ST_FULL;
            ST_FULL:  if (bus.alloc_ready_i) w_state_nxt = w_load ? ST_FULL : ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tag        <= '0;
            r_len        <= '0;
            r_src        <= '0;
            r_last_grant <= c_last_rst;
        end else if (w_load) begin
            r_tag        <= w_sel_tag;
            r_len        <= w_sel_len;
            r_src        <= w_winner;
            r_last_grant <= w_winner;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_inflight <= '0;
            r_rel_err  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_accept[i] && !w_dec[i]) begin
                    r_inflight[i] <= r_inflight[i] + CREDIT_WIDTH'(1);
                end else if (!w_accept[i] && w_dec[i]) begin
                    r_inflight[i] <= r_inflight[i] - CREDIT_WIDTH'(1);
                end
            end
            if (w_rel_err && (r_rel_err != 32'hFFFF_FFFF)) begin
                r_rel_err <= r_rel_err + 32'd1;
            end
        end
    end

    assign bus.alloc_valid_o = (r_state == ST_FULL);
    assign bus.alloc_tag_o   = r_tag;
    assign bus.alloc_len_o   = r_len;
    assign bus.alloc_src_o   = r_src;
    assign bus.inflight_o    = r_inflight;
    assign bus.release_err_o = r_rel_err;

endmodule

`default_nettype wire

// File: tb/tb_pspin_alloc_arb.sv
// ============================================================================
//  Module   : tb_pspin_alloc_arb
//  Brief    : Directed and randomized checks of pspin_alloc_arb.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pspin_alloc_arb;
    logic clk = 1'b0;
    logic rstn1;
    logic rstn2;
    always #5 clk = ~clk;

    pspin_alloc_arb_if #(.NUM_REQ(4), .LEN_WIDTH(20), .TAG_WIDTH(32), .CREDIT_WIDTH(8)) bus1 ();
    pspin_alloc_arb_if #(.NUM_REQ(4), .LEN_WIDTH(20), .TAG_WIDTH(32), .CREDIT_WIDTH(8)) bus2 ();

    pspin_alloc_arb #(.NUM_REQ(4), .LEN_WIDTH(20), .TAG_WIDTH(32), .CREDIT_WIDTH(8),
                      .MAX_INFLIGHT(64)) dut1 (.clk(clk), .rstn(rstn1), .bus(bus1));
    pspin_alloc_arb #(.NUM_REQ(4), .LEN_WIDTH(20), .TAG_WIDTH(32), .CREDIT_WIDTH(8),
                      .MAX_INFLIGHT(2))  dut2 (.clk(clk), .rstn(rstn2), .bus(bus2));

    int checks = 0;
    int errors = 0;

    // Reference model for dut2 (MAX_INFLIGHT = 2)
    int          m_inf [4];
    bit          m_full;
    logic [31:0] m_tag;
    logic [19:0] m_len;
    int          m_src, m_last, m_err, m_win, m_idx;
    bit          m_rel_ok;
    logic [3:0]  m_rdy;
    logic [3:0]  r_v;
    bit          r_ry, r_rv;
    logic [1:0]  r_rs;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic d1(input logic [3:0] v, input logic ry, input logic rv, input logic [1:0] rs);
        @(negedge clk);
        bus1.req_valid_i     = v;
        bus1.alloc_ready_i   = ry;
        bus1.release_valid_i = rv;
        bus1.release_src_i   = rs;
        #1;
    endtask

    task automatic d2(input logic [3:0] v, input logic ry, input logic rv, input logic [1:0] rs);
        @(negedge clk);
        bus2.req_valid_i     = v;
        bus2.alloc_ready_i   = ry;
        bus2.release_valid_i = rv;
        bus2.release_src_i   = rs;
        #1;
    endtask

    task automatic post();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn1 = 1'b0;
        rstn2 = 1'b0;
        bus1.req_tag_i = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        bus1.req_len_i = {20'd4, 20'd3, 20'd2, 20'd1};
        bus1.req_valid_i = 4'hF;
        bus1.alloc_ready_i = 1'b0;
        bus1.release_valid_i = 1'b0;
        bus1.release_src_i = 2'd0;
        bus2.req_tag_i = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        bus2.req_len_i = {20'd8, 20'd7, 20'd6, 20'd5};
        bus2.req_valid_i = 4'h0;
        bus2.alloc_ready_i = 1'b0;
        bus2.release_valid_i = 1'b0;
        bus2.release_src_i = 2'd0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", bus1.req_ready_o, 4'h0);
        chk("rst_valid", bus1.alloc_valid_o, 1'b0);
        chk("rst_tag", bus1.alloc_tag_o, 32'h0);
        chk("rst_len", bus1.alloc_len_o, 20'h0);
        chk("rst_src", bus1.alloc_src_o, 2'd0);
        chk("rst_inflight", bus1.inflight_o, 32'h0);
        chk("rst_err", bus1.release_err_o, 32'h0);
        @(negedge clk);
        bus1.req_valid_i = 4'h0;
        rstn1 = 1'b1;
        rstn2 = 1'b1;

        // Release on idle requester 3
        d1(4'h0, 1'b1, 1'b1, 2'd3);
        post();
        chk("idle_rel_err", bus1.release_err_o, 32'd1);
        chk("idle_rel_inflight", bus1.inflight_o, 32'h0);

        // All requesters valid: grants 0,1,2,3,0
        for (int c = 0; c < 5; c++) begin
            d1(4'hF, 1'b1, 1'b0, 2'd0);
            chk("rr_ready", bus1.req_ready_o, 64'(1) << (c % 4));
            post();
            chk("rr_valid", bus1.alloc_valid_o, 1'b1);
            chk("rr_src", bus1.alloc_src_o, 64'(c % 4));
            chk("rr_tag", bus1.alloc_tag_o, 64'(32'hA0 + (c % 4)));
            chk("rr_len", bus1.alloc_len_o, 64'((c % 4) + 1));
        end
        chk("rr_inflight", bus1.inflight_o, 32'h01010102);
        d1(4'h0, 1'b1, 1'b0, 2'd0);
        post();
        chk("drain_valid", bus1.alloc_valid_o, 1'b0);

        // Requester 2 alone with allocator back-pressure
        d1(4'b0100, 1'b0, 1'b0, 2'd0);
        chk("bp_ready0", bus1.req_ready_o, 4'b0100);
        post();
        chk("bp_src", bus1.alloc_src_o, 2'd2);
        bus1.req_tag_i[95:64] = 32'h55;
        for (int c = 0; c < 4; c++) begin
            d1(4'b0100, 1'b0, 1'b0, 2'd0);
            chk("bp_ready_hold", bus1.req_ready_o, 4'b0000);
            post();
            chk("bp_valid_hold", bus1.alloc_valid_o, 1'b1);
            chk("bp_tag_hold", bus1.alloc_tag_o, 32'hA2);
        end
        d1(4'b0100, 1'b1, 1'b0, 2'd0);
        chk("bp_ready_rise", bus1.req_ready_o, 4'b0100);
        post();
        chk("bp_new_tag", bus1.alloc_tag_o, 32'h55);
        d1(4'h0, 1'b1, 1'b0, 2'd0);
        post();
        chk("bp_inflight2", bus1.inflight_o[23:16], 8'd3);

        // Coincident acceptance and release on requester 0
        d1(4'b0001, 1'b1, 1'b0, 2'd0);
        post();
        chk("co_inflight_pre", bus1.inflight_o[7:0], 8'd3);
        d1(4'b0001, 1'b1, 1'b1, 2'd0);
        chk("co_ready", bus1.req_ready_o, 4'b0001);
        post();
        chk("co_inflight", bus1.inflight_o[7:0], 8'd3);
        chk("co_err", bus1.release_err_o, 32'd1);
        d1(4'h0, 1'b1, 1'b0, 2'd0);
        post();

        // Asynchronous reset while FULL
        d1(4'b0010, 1'b0, 1'b0, 2'd0);
        post();
        chk("ar_full", bus1.alloc_valid_o, 1'b1);
        #2;
        rstn1 = 1'b0;
        bus1.req_valid_i = 4'h0;
        #1;
        chk("ar_valid", bus1.alloc_valid_o, 1'b0);
        chk("ar_tag", bus1.alloc_tag_o, 32'h0);
        @(negedge clk);
        rstn1 = 1'b1;
        d1(4'hF, 1'b1, 1'b0, 2'd0);
        chk("ar_first_ready", bus1.req_ready_o, 4'b0001);
        post();
        chk("ar_first_src", bus1.alloc_src_o, 2'd0);
        chk("ar_inflight", bus1.inflight_o, 32'h1);
        chk("ar_err", bus1.release_err_o, 32'h0);
        d1(4'h0, 1'b1, 1'b0, 2'd0);

        // In-flight limit of 2 on requester 1
        d2(4'b0010, 1'b1, 1'b0, 2'd0);
        chk("lim_ready1", bus2.req_ready_o, 4'b0010);
        post();
        chk("lim_src", bus2.alloc_src_o, 2'd1);
        d2(4'b0010, 1'b1, 1'b0, 2'd0);
        chk("lim_ready2", bus2.req_ready_o, 4'b0010);
        post();
        chk("lim_inflight2", bus2.inflight_o[15:8], 8'd2);
        d2(4'b0010, 1'b1, 1'b0, 2'd0);
        chk("lim_stall", bus2.req_ready_o, 4'b0000);
        post();
        chk("lim_drain", bus2.alloc_valid_o, 1'b0);
        d2(4'b0010, 1'b1, 1'b1, 2'd1);
        chk("lim_rel_ready", bus2.req_ready_o, 4'b0010);
        post();
        chk("lim_rel_valid", bus2.alloc_valid_o, 1'b1);
        chk("lim_rel_inflight", bus2.inflight_o[15:8], 8'd2);
        chk("lim_rel_err", bus2.release_err_o, 32'd0);

        // Randomized traffic on dut2 against the reference model
        d2(4'h0, 1'b0, 1'b0, 2'd0);
        rstn2 = 1'b0;
        @(negedge clk);
        rstn2 = 1'b1;
        for (int i = 0; i < 4; i++) m_inf[i] = 0;
        m_full = 1'b0; m_tag = '0; m_len = '0; m_src = 0; m_last = 3; m_err = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            r_v  = 4'($urandom_range(0, 15));
            r_ry = ($urandom_range(0, 3) != 0);
            r_rv = ($urandom_range(0, 2) == 0);
            r_rs = 2'($urandom_range(0, 3));
            bus2.req_valid_i = r_v;
            bus2.alloc_ready_i = r_ry;
            bus2.release_valid_i = r_rv;
            bus2.release_src_i = r_rs;
            for (int i = 0; i < 4; i++) begin
                bus2.req_tag_i[i*32 +: 32] = $urandom;
                bus2.req_len_i[i*20 +: 20] = 20'($urandom);
            end
            // Expected grant: first eligible after last winner, freed slots count immediately
            m_win = -1;
            if (!m_full || r_ry) begin
                for (int k = 1; k <= 4; k++) begin
                    m_idx = (m_last + k) % 4;
                    if (m_win < 0 && r_v[m_idx] &&
                        (m_inf[m_idx] - ((r_rv && r_rs == m_idx && m_inf[m_idx] > 0) ? 1 : 0)) < 2)
                        m_win = m_idx;
                end
            end
            m_rdy = (m_win >= 0) ? 4'(1 << m_win) : 4'h0;
            #1;
            chk("rnd_ready", bus2.req_ready_o, m_rdy);
            m_rel_ok = r_rv && (m_inf[r_rs] > 0 || m_win == int'(r_rs));
            if (m_win >= 0) m_inf[m_win]++;
            if (m_rel_ok) m_inf[r_rs]--;
            else if (r_rv) m_err++;
            if (m_win >= 0) begin
                m_full = 1'b1;
                m_tag  = bus2.req_tag_i[m_win*32 +: 32];
                m_len  = bus2.req_len_i[m_win*20 +: 20];
                m_src  = m_win;
                m_last = m_win;
            end else if (m_full && r_ry) begin
                m_full = 1'b0;
            end
            post();
            chk("rnd_valid", bus2.alloc_valid_o, m_full);
            if (m_full) begin
                chk("rnd_tag", bus2.alloc_tag_o, m_tag);
                chk("rnd_len", bus2.alloc_len_o, m_len);
                chk("rnd_src", bus2.alloc_src_o, 64'(m_src));
            end
            chk("rnd_inflight", bus2.inflight_o,
                {8'(m_inf[3]), 8'(m_inf[2]), 8'(m_inf[1]), 8'(m_inf[0])});
            chk("rnd_err", bus2.release_err_o, 64'(m_err));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
